// File: rtl/regfile_dbg_pkg.sv
// regfile_dbg_pkg: shared states and constants for the register-file debug walker.
package regfile_dbg_pkg;
  typedef enum logic [2:0] {S_IDLE, S_HALT_WAIT, S_READ, S_SEND, S_CLEAR, S_FINISH} state_t;
  localparam logic MODE_DUMP = 1'b0;
  localparam logic MODE_CLEAR = 1'b1;
  localparam int ZERO_REG = 0;
  localparam int NUM_REGS_DEF = 32;
endpackage

// File: rtl/regfile_dump_ctrl.sv
// regfile_dump_ctrl: halts the core, then dumps or clears the register file.
module regfile_dump_ctrl
  import regfile_dbg_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W = $clog2(NUM_REGS),
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic              cpu_halted,
  output logic              halt_req,
  output logic [ADDR_W-1:0] rf_read_addr,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic              rf_write_en,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_index,
  output logic [DATA_W-1:0] dump_data,
  output logic              busy,
  output logic              done,
  output logic              aborted
);
  state_t state, state_n;
  logic [ADDR_W-1:0] idx;
  logic mode_q, last, live, abort, step;
  assign last = idx == ADDR_W'(NUM_REGS - 1);
  assign live = state == S_READ || state == S_SEND || state == S_CLEAR;
  assign abort = live && !cpu_halted;
  assign step = !abort && !last && ((state == S_SEND && dump_ready) || state == S_CLEAR);
  always_ff @(posedge clk)
    if (rst) state <= S_IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:      state_n = start ? S_HALT_WAIT : S_IDLE;
      S_HALT_WAIT: state_n = !cpu_halted ? S_HALT_WAIT : (mode_q == MODE_CLEAR ? S_CLEAR : S_READ);
      S_READ:      state_n = S_SEND;
      S_SEND:      state_n = !dump_ready ? S_SEND : (last ? S_FINISH : S_READ);
      S_CLEAR:     state_n = last ? S_FINISH : S_CLEAR;
      default:     state_n = S_IDLE;
    endcase
    if (abort) state_n = S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      mode_q <= MODE_DUMP;
      halt_req <= 1'b0;
      dump_index <= '0;
      dump_data <= '0;
      aborted <= 1'b0;
    end else begin
      aborted <= abort;
      if (state == S_IDLE && start) begin
        mode_q <= mode;
        idx <= mode == MODE_DUMP ? ADDR_W'(ZERO_REG) : ADDR_W'(ZERO_REG + 1);
        halt_req <= 1'b1;
      end
      if (state == S_FINISH || abort) halt_req <= 1'b0;
      if (state == S_READ) begin
        dump_index <= idx;
        dump_data <= rf_read_data;
      end
      if (step) idx <= idx + 1'b1;
    end
  end
  // Gating by cpu_halted drops a pending beat/write in the very cycle the core resumes.
  assign dump_valid = state == S_SEND && cpu_halted;
  assign rf_write_en = state == S_CLEAR && cpu_halted;
  assign rf_read_addr = state == S_READ ? idx : '0;
  assign rf_write_addr = state == S_CLEAR ? idx : '0;
  assign rf_write_data = '0;
  assign busy = state != S_IDLE;
  assign done = state == S_FINISH;
endmodule
